jk_reg_bank: RTL and testbench

Parametrised bank of WIDTH JK flip-flops sharing one clock and one synchronous reset. It generalises the single JK flip-flop into a multi-bit register with four modes:
- per-bit JK
- binary up-count
- binary down-count
- parallel load

It provides optional saturation and a terminal-count flag. It serves as the general-purpose state/counter element for sequential blocks in the flip-flop library.

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_cell.sv | 29 ++
 rtl/jk_reg_bank.sv | 93 +++++++++
 tb/tb_jk_reg_bank.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to rst_val.
// Latency: one clock edge from j/k to q.
// Backpressure: none; the cell updates on every edge. Hold is j=k=0.
module jk_cell (
    input  logic clock,
    input  logic reset,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= rst_val;
        end else begin
            unique case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule : jk_cell

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells: per-bit JK, up/down count, or parallel load.
// Latency: one clock edge to q/q_bar; tc is combinational from q and mode.
// Backpressure: en=0 holds q in every mode; there is no handshake.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    mode_e            modeSel;
    logic [WIDTH-1:0] lowOnes;
    logic [WIDTH-1:0] lowZeros;
    logic [WIDTH-1:0] cellJ;
    logic [WIDTH-1:0] cellK;
    logic             isMax;
    logic             isZero;

    assign modeSel = mode_e'(mode);
    assign isMax   = &q;
    assign isZero  = ~|q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        if (i == 0) begin : gLsb
            assign lowOnes[i]  = 1'b1;
            assign lowZeros[i] = 1'b1;
        end else begin : gUpper
            assign lowOnes[i]  = &q[i-1:0];
            assign lowZeros[i] = ~|q[i-1:0];
        end

        jk_cell uCell (
            .clock   (clock),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .j       (cellJ[i]),
            .k       (cellK[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i])
        );
    end

    always_comb begin
        cellJ = '0;
        cellK = '0;
        unique case (modeSel)
            MODE_JK: begin
                cellJ = j;
                cellK = k;
            end
            MODE_UP: begin
                if (!(SATURATE && isMax)) begin
                    cellJ = lowOnes;
                    cellK = lowOnes;
                end
            end
            MODE_DOWN: begin
                if (!(SATURATE && isZero)) begin
                    cellJ = lowZeros;
                    cellK = lowZeros;
                end
            end
            MODE_LOAD: begin
                cellJ = load_val;
                cellK = ~load_val;
            end
            default: begin
                cellJ = '0;
                cellK = '0;
            end
        endcase
        if (!en) begin
            cellJ = '0;
            cellK = '0;
        end
    end

    assign tc = ((modeSel == MODE_UP) && isMax) || ((modeSel == MODE_DOWN) && isZero);

endmodule : jk_reg_bank

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench: a wrap-around and a saturating bank driven with identical stimulus.
module tb_jk_reg_bank;

    localparam int         W  = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0, k = '0, load_val = '0;
    logic [W-1:0] q0, qb0, q1, qb1;
    logic         tc0, tc1;

    always #5 clock = ~clock;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q0), .q_bar(qb0), .tc(tc0)
    );

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q1), .q_bar(qb1), .tc(tc1)
    );

    typedef struct {
        logic [W-1:0] q0;
        logic [W-1:0] q1;
        logic         tc0;
        logic         tc1;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m0, m1;

    // Reference model: plain arithmetic per the mode rules.
    function automatic logic [W-1:0] modelNext(input logic [W-1:0] cur, input logic r,
                                               input logic e, input logic [1:0] md,
                                               input logic [W-1:0] jj, input logic [W-1:0] kk,
                                               input logic [W-1:0] lv, input bit sat);
        logic [W-1:0] res;
        int           maxv;
        maxv = (1 << W) - 1;
        res  = cur;
        if (r) return RV;
        if (!e) return cur;
        case (md)
            2'd0: begin
                for (int b = 0; b < W; b++) begin
                    if (jj[b] && kk[b])  res[b] = ~cur[b];
                    else if (jj[b])      res[b] = 1'b1;
                    else if (kk[b])      res[b] = 1'b0;
                end
            end
            2'd1: res = (sat && int'(cur) == maxv) ? cur : W'((int'(cur) + 1) % (maxv + 1));
            2'd2: res = (sat && cur == 0) ? cur : W'((int'(cur) + maxv) % (maxv + 1));
            default: res = lv;
        endcase
        return res;
    endfunction

    function automatic logic modelTc(input logic [W-1:0] cur, input logic [1:0] md);
        if (md == 2'd1) return int'(cur) == (1 << W) - 1;
        if (md == 2'd2) return cur == 0;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] md,
                         input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] lv);
        exp_t x;
        @(negedge clock);
        reset = r; en = e; mode = md; j = jj; k = kk; load_val = lv;
        m0 = modelNext(m0, r, e, md, jj, kk, lv, 1'b0);
        m1 = modelNext(m1, r, e, md, jj, kk, lv, 1'b1);
        x.q0  = m0;
        x.q1  = m1;
        x.tc0 = modelTc(m0, md);
        x.tc1 = modelTc(m1, md);
        sb.push_back(x);
    endtask

    // Monitor: one scoreboard entry per edge; mode is stable until the next negedge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int b = 0; b < W; b++) begin
                chk($sformatf("q0[%0d]", b), W'(q0[b]), W'(e.q0[b]));
                chk($sformatf("q1[%0d]", b), W'(q1[b]), W'(e.q1[b]));
            end
            chk("q_bar0", qb0, ~e.q0);
            chk("q_bar1", qb1, ~e.q1);
            chk("tc0", W'(tc0), W'(e.tc0));
            chk("tc1", W'(tc1), W'(e.tc1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        m0 = 'x;
        m1 = 'x;
        // Reset, then one count step from RESET_VAL.
        drive(1, 0, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        drive(0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        // Per-bit JK from 0000.
        drive(0, 1, 2'd3, 4'b0000, 4'b0000, 4'b0000);
        drive(0, 1, 2'd0, 4'b1100, 4'b1010, 4'b0000);
        drive(0, 1, 2'd0, 4'b1100, 4'b1010, 4'b0000);
        drive(0, 1, 2'd0, 4'b1111, 4'b1111, 4'b0000);
        // Up wrap / saturate from 1110.
        drive(0, 1, 2'd3, 4'b0000, 4'b0000, 4'b1110);
        repeat (3) drive(0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        // Down from 0001: wrap vs saturate.
        drive(0, 1, 2'd3, 4'b0000, 4'b0000, 4'b0001);
        repeat (4) drive(0, 1, 2'd2, 4'b0000, 4'b0000, 4'b0000);
        // Load, then hold with en=0.
        drive(0, 1, 2'd3, 4'b1111, 4'b1111, 4'b0110);
        repeat (3) drive(0, 0, 2'd1, 4'b1111, 4'b0000, 4'b1001);
        // Reset in the middle of counting.
        drive(0, 1, 2'd3, 4'b0000, 4'b0000, 4'b0101);
        drive(0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        drive(1, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) drive(0, 1, 2'd1, 4'b0000, 4'b0000, 4'b0000);
        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom));
        end
        repeat (2) @(negedge clock);
        chk("drain", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jk_reg_bank
